// File: rtl/mole_pkg.sv
// Shared types and widths for the whack-a-mole round controller.
package mole_pkg;

   localparam int KEY_W  = 4;
   localparam int CNT_W  = 8;
   localparam int LFSR_W = 16;
   localparam int MS_W   = 16;

   // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SPAWN,
      ST_UP,
      ST_GAP,
      ST_OVER
   } state_t;

   // Saturating add of a small increment to a score/miss counter
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                input logic [1:0]       inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR used to pick mole holes.
module mole_lfsr
   import mole_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   output logic [LFSR_W-1:0] o_lfsr
);

   // Advance one step every clock; seed restored on reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) o_lfsr <= SEED;
      else      o_lfsr <= {1'b0, o_lfsr[LFSR_W-1:1]} ^ (o_lfsr[0] ? LFSR_TAPS : '0);
   end

endmodule

// File: rtl/mole_hit_judge.sv
// Whack-a-mole round controller: spawns moles, judges key strobes, keeps score.
// Optional feature: define MOLE_SPEEDUP_EN to shorten mole life after each hit.
module mole_hit_judge
   import mole_pkg::*;
#(
   parameter int               TICK_DIV     = 50000,
   parameter int               MOLE_LIFE_MS = 1000,
   parameter int               LIFE_MIN_MS  = 300,
   parameter int               GAP_MS       = 200,
   parameter int               GAME_MOLES   = 30,
   parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [KEY_W-1:0] i_key,
   input  logic             i_key_en,
   output logic [KEY_W-1:0] o_mole_pos,
   output logic             o_mole_vld,
   output logic             o_hit_pulse,
   output logic [CNT_W-1:0] o_score,
   output logic [CNT_W-1:0] o_miss,
   output logic             o_busy,
   output logic             o_game_over
);

   localparam int               PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]    PRE_MAX   = PW'(TICK_DIV - 1);
   localparam logic [MS_W-1:0]  LIFE_INIT = MS_W'(MOLE_LIFE_MS);
   localparam logic [MS_W-1:0]  GAP_LAST  = MS_W'(GAP_MS - 1);
   localparam logic [CNT_W-1:0] GAME_N    = CNT_W'(GAME_MOLES);

   state_t             state, state_nx;
   logic [PW-1:0]      pre;
   logic               ms_tick;
   logic [LFSR_W-1:0]  lfsr;
   logic               lfsr_unused;
   logic [MS_W-1:0]    ms_cnt;
   logic [MS_W-1:0]    life;
   logic [CNT_W-1:0]   mole_cnt;
   logic [KEY_W-1:0]   cand;
   logic [1:0]         miss_inc;
   logic               key_match, hit, wrong, expire, gap_done, start_ok;

   mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .o_lfsr (lfsr)
   );

   // Only the low nibble selects a hole
   assign lfsr_unused = ^lfsr[LFSR_W-1:KEY_W];

   // Millisecond prescaler, free running from reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              pre <= '0;
      else if (pre == PRE_MAX) pre <= '0;
      else                   pre <= pre + 1'b1;
   end

   assign ms_tick   = (pre == PRE_MAX);
   assign key_match = i_key_en && (i_key == o_mole_pos);
   assign hit       = (state == ST_UP) && key_match;
   assign wrong     = (state == ST_UP) && i_key_en && !key_match;
   // A hit landing on the expiry tick takes precedence
   assign expire    = (state == ST_UP) && ms_tick && (ms_cnt == life - 1'b1) && !hit;
   assign gap_done  = (state == ST_GAP) && ms_tick && (ms_cnt == GAP_LAST);
   assign start_ok  = i_start && ((state == ST_IDLE) || (state == ST_OVER));
   assign miss_inc  = {1'b0, wrong} + {1'b0, expire};

   // Avoid repeating the last hole, except for the first mole of a round
   assign cand = ((mole_cnt != '0) && (lfsr[KEY_W-1:0] == o_mole_pos)) ?
                 lfsr[KEY_W-1:0] + 1'b1 : lfsr[KEY_W-1:0];

`ifdef MOLE_SPEEDUP_EN
   localparam logic [MS_W-1:0] LIFE_FLOOR = MS_W'(LIFE_MIN_MS);
   logic [MS_W-1:0] life_dec;
   assign life_dec = life - (life >> 4);

   // Mole life shrinks by 1/16 per hit down to the floor; reloads per round
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          life <= LIFE_INIT;
      else if (start_ok) life <= LIFE_INIT;
      else if (hit)      life <= (life_dec < LIFE_FLOOR) ? LIFE_FLOOR : life_dec;
   end
`else
   logic [MS_W-1:0] life_min_unused;
   assign life_min_unused = MS_W'(LIFE_MIN_MS);
   assign life            = LIFE_INIT;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   // Round sequencing
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE, ST_OVER: if (i_start) state_nx = ST_SPAWN;
         ST_SPAWN:         state_nx = ST_UP;
         ST_UP:            if (hit || expire) state_nx = ST_GAP;
         ST_GAP:           if (gap_done) state_nx = (mole_cnt == GAME_N) ? ST_OVER : ST_SPAWN;
         default:          state_nx = ST_IDLE;
      endcase
   end

   // Mole placement, ms counting and score/miss bookkeeping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_mole_pos  <= '0;
         o_hit_pulse <= 1'b0;
         o_score     <= '0;
         o_miss      <= '0;
         mole_cnt    <= '0;
         ms_cnt      <= '0;
      end else begin
         o_hit_pulse <= hit;
         if (start_ok) begin
            o_score  <= '0;
            o_miss   <= '0;
            mole_cnt <= '0;
         end
         if (state == ST_SPAWN) begin
            o_mole_pos <= cand;
            mole_cnt   <= sat_add(mole_cnt, 2'd1);
            ms_cnt     <= '0;
         end else if (hit || expire) begin
            ms_cnt <= '0;
         end else if (((state == ST_UP) || (state == ST_GAP)) && ms_tick) begin
            ms_cnt <= ms_cnt + 1'b1;
         end
         if (hit)            o_score <= sat_add(o_score, 2'd1);
         if (state == ST_UP) o_miss  <= sat_add(o_miss, miss_inc);
      end
   end

   assign o_mole_vld  = (state == ST_UP);
   assign o_busy      = (state == ST_SPAWN) || (state == ST_UP) || (state == ST_GAP);
   assign o_game_over = (state == ST_OVER);

endmodule

// File: tb/tb_mole_hit_judge.sv
// Self-checking bench for mole_hit_judge with randomized key activity.
module tb_mole_hit_judge;

   localparam int          TD    = 10;
   localparam int          LIFE  = 20;
   localparam int          LMIN  = 10;
   localparam int          GAPMS = 5;
   localparam int          GM    = 3;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic       clk = 0;
   logic       rst = 0;
   logic       i_start = 0;
   logic [3:0] i_key = 0;
   logic       i_key_en = 0;
   logic [3:0] o_mole_pos;
   logic       o_mole_vld, o_hit_pulse, o_busy, o_game_over;
   logic [7:0] o_score, o_miss;

   mole_hit_judge #(
      .TICK_DIV(TD), .MOLE_LIFE_MS(LIFE), .LIFE_MIN_MS(LMIN),
      .GAP_MS(GAPMS), .GAME_MOLES(GM), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_key(i_key), .i_key_en(i_key_en),
      .o_mole_pos(o_mole_pos), .o_mole_vld(o_mole_vld), .o_hit_pulse(o_hit_pulse),
      .o_score(o_score), .o_miss(o_miss), .o_busy(o_busy), .o_game_over(o_game_over)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference: LFSR sequence and ms tick phase since reset release
   logic [15:0] lfsr_m, lfsr_prev;
   int          pre_m;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_m    <= SEED;
         lfsr_prev <= SEED;
         pre_m     <= 0;
      end else begin
         lfsr_prev <= lfsr_m;
         lfsr_m    <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
         pre_m     <= (pre_m + 1) % TD;
      end
   end

   int         exp_score, exp_miss, mole_cnt_m, life_m;
   logic [3:0] prev_pos, cur_pos;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_pos"}, o_mole_pos, 0);
      chk({tag, "_vld"}, o_mole_vld, 0);
      chk({tag, "_hit"}, o_hit_pulse, 0);
      chk({tag, "_score"}, o_score, 0);
      chk({tag, "_miss"}, o_miss, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_over"}, o_game_over, 0);
   endtask

   // Called on the first negedge after the spawn edge
   task automatic up_check();
      logic [3:0] c;
      c = lfsr_prev[3:0];
      if (mole_cnt_m != 0 && c == prev_pos) c = c + 4'd1;
      mole_cnt_m++;
      chk("up_vld", o_mole_vld, 1);
      chk("up_pos", o_mole_pos, c);
      chk("up_busy", o_busy, 1);
      cur_pos = c;
   endtask

   task automatic start_round();
      i_start = 1;
      @(negedge clk);
      i_start = 0;
      exp_score = 0; exp_miss = 0; mole_cnt_m = 0; life_m = LIFE;
      chk("spawn_busy", o_busy, 1);
      chk("spawn_vld", o_mole_vld, 0);
      chk("spawn_score", o_score, 0);
      chk("spawn_miss", o_miss, 0);
      @(negedge clk);
      up_check();
   endtask

   // mode 0: hit after random delay; 1: one wrong key then expiry;
   // 2: hit on the expiry cycle; 3: random presses
   task automatic play_mole(input int mode);
      int   ticks, d, wk;
      bit   done, tick_nx, en, hitm, wrongm, expm;
      logic [3:0] k;
      ticks = 0; done = 0;
      d  = $urandom_range(0, 150);
      wk = $urandom_range(0, 100);
      for (int n = 0; n < 600 && !done; n++) begin
         tick_nx = (pre_m == TD - 1);
         en = 0; k = 4'($urandom);
         case (mode)
            0: if (n == d) begin en = 1; k = cur_pos; end
            1: if (n == wk) begin en = 1; k = cur_pos ^ 4'($urandom_range(1, 15)); end
            2: if (tick_nx && ticks == life_m - 1) begin en = 1; k = cur_pos; end
            default: if ($urandom_range(0, 29) == 0) begin
               en = 1;
               if ($urandom_range(0, 1) == 1) k = cur_pos;
            end
         endcase
         i_key_en = en; i_key = k;
         @(negedge clk);
         i_key_en = 0;
         hitm   = en && (k == cur_pos);
         wrongm = en && !hitm;
         expm   = !hitm && tick_nx && (ticks == life_m - 1);
         if (hitm) begin
            exp_score = (exp_score < 255) ? exp_score + 1 : 255;
`ifdef MOLE_SPEEDUP_EN
            life_m = life_m - life_m / 16;
            if (life_m < LMIN) life_m = LMIN;
`endif
         end
         exp_miss = exp_miss + int'(wrongm) + int'(expm);
         if (exp_miss > 255) exp_miss = 255;
         chk("up_hit_pulse", o_hit_pulse, hitm);
         chk("up_score", o_score, exp_score);
         chk("up_miss", o_miss, exp_miss);
         chk("up_vld_now", o_mole_vld, !(hitm || expm));
         if (hitm || expm) done = 1;
         else if (tick_nx) ticks++;
      end
      if (!done) chk("up_timeout", 0, 1);
      // Gap: keys and start are noise here and must be ignored
      ticks = 0; done = 0;
      for (int n = 0; n < 200 && !done; n++) begin
         tick_nx  = (pre_m == TD - 1);
         i_key_en = ($urandom_range(0, 3) == 0);
         i_key    = ($urandom_range(0, 1) == 1) ? cur_pos : 4'($urandom);
         i_start  = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         i_key_en = 0; i_start = 0;
         chk("gap_hit_pulse", o_hit_pulse, 0);
         chk("gap_score", o_score, exp_score);
         chk("gap_miss", o_miss, exp_miss);
         chk("gap_vld", o_mole_vld, 0);
         if (tick_nx && ticks == GAPMS - 1) begin
            done = 1;
            if (mole_cnt_m == GM) begin
               chk("over_flag", o_game_over, 1);
               chk("over_busy", o_busy, 0);
            end else begin
               chk("respawn_busy", o_busy, 1);
               chk("respawn_over", o_game_over, 0);
               prev_pos = cur_pos;
               @(negedge clk);
               up_check();
            end
         end else begin
            if (tick_nx) ticks++;
            chk("gap_busy", o_busy, 1);
         end
      end
      if (!done) chk("gap_timeout", 0, 1);
   endtask

   // Keys pressed while the round is over change nothing
   task automatic over_idle();
      for (int n = 0; n < 8; n++) begin
         i_key_en = 1; i_key = 4'($urandom);
         @(negedge clk);
         i_key_en = 0;
         chk("over_hold_flag", o_game_over, 1);
         chk("over_hold_score", o_score, exp_score);
         chk("over_hold_miss", o_miss, exp_miss);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      rst = 1;
      // Keys in IDLE are ignored
      for (int n = 0; n < 5; n++) begin
         i_key_en = 1; i_key = 4'($urandom);
         @(negedge clk);
         i_key_en = 0;
         chk_idle_outputs("idle");
      end

      // Round 1: directed behaviours
      start_round();
      play_mole(0);
      play_mole(1);
      play_mole(2);
      over_idle();

      // Round 2: random presses, restart from OVER
      start_round();
      for (int m = 0; m < GM; m++) play_mole(3);
      over_idle();

      // Round 3: asynchronous reset while a mole is up
      start_round();
      repeat ($urandom_range(5, 50)) @(negedge clk);
      #2 rst = 0;
      #1 chk_idle_outputs("async_rst");
      repeat (3) @(negedge clk);
      chk_idle_outputs("rst_held");
      rst = 1;
      @(negedge clk);
      chk_idle_outputs("rst_release");

      // Round 4: full random round after reset
      start_round();
      for (int m = 0; m < GM; m++) play_mole(3);
      over_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
